mem_io_bus: RTL
===============

// Module: mem_io_bus
// PURPOSE
//   Data-side memory/IO stage downstream of the 16-bit processor. It consumes the
//   address and store data the core latches (ADDR/DOUT) plus a request strobe.
//   It decodes each access to an on-chip data RAM, an LED output register or a
//   7-segment value register, and returns a single-cycle ack with read data.
//   Unmapped accesses complete with an error pulse and never hang the core.
// PARAMETERS
//   DATA_W     16   data bus width
//   RAM_AW     7    data RAM address bits (2**RAM_AW words)
//   LED_RST    0    reset value of the LED register
// PORTS
//   clock      in   1        system clock, rising edge
//   resetn     in   1        asynchronous active-low reset
//   req        in   1        access request; held high until ack
//   we         in   1        1 = write, 0 = read; stable while req is high
//   addr       in   16       byte-free word address; stable while req is high
//   wdata      in   DATA_W   store data; stable while req is high
//   ack        out  1        one-cycle completion pulse
//   rdata      out  DATA_W   read data, valid in the ack cycle and held afterwards
//   err        out  1        one-cycle pulse with ack on an unmapped access
//   leds       out  16       LED register
//   hex_val    out  16       7-segment display value register
//   busy       out  1        high whenever FSM != IDLE
// BEHAVIOUR
//   Reset (async, resetn=0): FSM=IDLE; ack=0, err=0, busy=0, rdata=0,
//     leds=LED_RST, hex_val=0. RAM contents are not cleared.
//   Address map:
//     addr[15:12]=0 and addr[11:RAM_AW]=0  -> RAM[addr[RAM_AW-1:0]]
//     addr=16'h1000                        -> leds (R/W)
//     addr=16'h1001                        -> hex_val (R/W)
//     anything else                        -> unmapped
//   FSM states: IDLE, RD_WAIT, RESP.
//     IDLE: on req=1, latch we/addr/wdata; this is accept cycle T.
//       RAM write, IO write, IO read, unmapped -> RESP.
//       RAM read -> RD_WAIT; the synchronous RAM is addressed at edge T.
//     RD_WAIT: capture the RAM output into rdata -> RESP.
//     RESP: ack=1 for exactly one cycle -> IDLE.
//   Latency from accept T: ack in cycle T+1 for writes, IO reads and unmapped;
//     ack in T+2 for RAM reads.
//   Writes: the RAM/leds/hex_val are updated at the edge ending cycle T.
//     rdata is unchanged on writes.
//   IO reads: rdata = register value sampled in cycle T.
//   Unmapped: err=1 in the same cycle as ack. No state is modified.
//     On a read, rdata=0.
//   req is ignored in RD_WAIT and RESP. The core must drop req in the ack cycle.
//     If req is still high in IDLE after RESP, it is a new access.
//     Minimum spacing is therefore 2 cycles/access (write), 3 cycles (RAM read).
//   Width: addr bits above the decode are compared exactly, with no aliasing.
//     RAM index wraps never; out-of-range goes to unmapped.
//   Reset mid-access: the access is abandoned and no ack is issued.
//     A RAM write accepted before the reset edge may or may not have landed.
//     leds/hex_val return to reset values.
// TESTING
//   1 Reset: hold resetn=0 3 cycles -> ack=0, err=0, busy=0, leds=LED_RST, hex_val=0, rdata=0.
//   2 RAM write/read: write 16'hBEEF @0x0005 (ack T+1), then read @0x0005
//     -> ack at T+2, rdata=16'hBEEF.
//   3 IO: write 16'h00FF @0x1000 -> leds=16'h00FF the cycle after accept.
//     Read @0x1000 -> rdata=16'h00FF, ack T+1.
//   4 Unmapped: read @0x0080 (RAM_AW=7) and write @0x2000 -> ack+err together.
//     rdata=0, leds/hex_val/RAM[0] unchanged.
//   5 Back-to-back: req held high across 3 writes to RAM 0,1,2 -> 3 acks spaced 2 cycles.
//     Readback of all three matches.
//   6 Reset mid-read: assert resetn=0 in RD_WAIT -> no ack, FSM IDLE.
//     A subsequent read of the same word returns the prior written value.

Source files
------------

// File: rtl/mem_io_bus.sv
// Data-side memory/IO stage: decodes core accesses to data RAM, LED and 7-seg registers.
// Ports: clock/resetn, req/we/addr/wdata request, ack/rdata/err response, leds, hex_val, busy.
module mem_io_bus #(
    parameter int          DATA_W  = 16,
    parameter int          RAM_AW  = 7,
    parameter logic [15:0] LED_RST = 16'h0000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              we,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [15:0]       leds,
    output logic [15:0]       hex_val,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] ram [2**RAM_AW];
    logic [DATA_W-1:0] ram_q;
    logic              resp_err;

    logic ram_hit;
    logic led_hit;
    logic hex_hit;
    logic accept;

    // Every bit above the RAM index must be zero: no aliasing into RAM.
    assign ram_hit = (addr[15:RAM_AW] == '0);
    assign led_hit = (addr == 16'h1000);
    assign hex_hit = (addr == 16'h1001);
    assign accept  = (state == IDLE) && req;

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        err      = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (ram_hit && !we) ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: begin
                state_nx = RESP;
            end
            RESP: begin
                ack      = 1'b1;
                err      = resp_err;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rdata    <= '0;
            leds     <= LED_RST;
            hex_val  <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                resp_err <= !(ram_hit || led_hit || hex_hit);
                if (we) begin
                    if (led_hit) leds <= 16'(wdata);
                    if (hex_hit) hex_val <= 16'(wdata);
                end else if (led_hit) begin
                    rdata <= DATA_W'(leds);
                end else if (hex_hit) begin
                    rdata <= DATA_W'(hex_val);
                end else if (!ram_hit) begin
                    rdata <= '0;
                end
            end
            if (state == RD_WAIT) begin
                rdata <= ram_q;
            end
        end
    end

    // RAM has no reset; the read port is registered at the accept edge.
    always_ff @(posedge clock) begin
        if (accept && ram_hit) begin
            if (we) begin
                ram[addr[RAM_AW-1:0]] <= wdata;
            end else begin
                ram_q <= ram[addr[RAM_AW-1:0]];
            end
        end
    end

endmodule
